poly1305_block_feeder: RTL and testbench
========================================

// Module: poly1305_block_feeder
// PURPOSE
//  Producer side of the Poly1305 AAD/payload/length block interface. Accepts AAD and payload
//  as 128-bit beats with byte keeps, zero-pads partial final blocks, counts bytes and builds the
//  RFC 8439 length block le64(aad_len)||le64(pld_len). Sits between the AEAD datapath and the
//  Poly1305 core, one block in flight: each block waits for the core's stage-done pulse.
// PARAMETERS
//  CNT_W  36  byte-counter width; counts zero-extended to 64 bits in the length block
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    begin message; sampled in IDLE/DONE/ERR only
//  cfg_aad_en   in   1    AAD stage present (sampled with start)
//  cfg_pld_en   in   1    payload stage present (sampled with start)
//  s_aad_valid/s_aad_ready  in/out 1   upstream AAD handshake
//  s_aad_data   in   128  AAD beat, byte i at bits [8i+7:8i]
//  s_aad_keep   in   16   byte enables; s_aad_last in 1 = final AAD beat
//  s_pld_valid/s_pld_ready  in/out 1   upstream payload handshake
//  s_pld_data   in   128  payload beat; s_pld_keep in 16; s_pld_last in 1
//  aad_valid    out  1    to core; aad_data out 128; aad_keep out 16; aad_ready in 1
//  pld_valid    out  1    to core; pld_data out 128; pld_keep out 16; pld_ready in 1
//  len_valid    out  1    to core; len_block out 128; len_ready in 1
//  aad_done/pld_done/lens_done  in 1  one-cycle stage-done pulses from core
//  busy         out  1    high outside IDLE/DONE/ERR
//  done         out  1    one-cycle pulse when lens_done is accepted
//  err          out  1    sticky framing error, cleared by next accepted start
//  aad_bytes    out  CNT_W  AAD bytes accepted this message; pld_bytes out CNT_W likewise
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-message aborts with no further beats.
//  States: IDLE, A_RX, A_TX, A_ACK, P_RX, P_TX, P_ACK, L_TX, L_ACK, DONE, ERR.
//  start in IDLE/DONE/ERR: clear counters and err; go A_RX if cfg_aad_en, else P_RX if
//   cfg_pld_en, else L_TX. start in any other state is ignored.
//  X_RX: s_x_ready=1 (combinational on state); on s_x_valid capture beat -> X_TX next cycle.
//   Data bytes with keep=0 are forced to 0 in the register; keep forwarded as captured.
//  X_TX: x_valid=1, data/keep held stable until x_ready; on handshake -> X_ACK.
//  X_ACK: wait x_done pulse; then captured last ? next stage : X_RX. Next stage of AAD is P_RX
//   if cfg_pld_en else L_TX; of payload is L_TX.
//  Latency: upstream accept cycle N -> downstream valid N+1 (min 1-cycle downstream stall 0).
//  Counters add popcount(keep) at upstream capture; wrap modulo 2^CNT_W (no saturation).
//  len_block = {64'(pld_bytes), 64'(aad_bytes)}, registered on L_TX entry.
//  L_ACK on lens_done -> DONE, done pulses that same cycle. DONE holds counts until start.
//  Keep legality: keep must be 2^k-1, k=1..16. keep!=16'hFFFF only legal with last=1.
//   Violation: beat is not forwarded, err=1, state ERR, all readies/valids 0 until start.
//  Done pulses outside the matching X_ACK state are ignored. x_ready while x_valid=0 ignored.
//  Simultaneous s_x_valid and start outside idle states: start ignored, beat processed.
//  busy=1 in every state except IDLE, DONE, ERR.
// TESTING
//  1. AAD 16B full last, pld 16B full last -> one beat each, len_block={64'd16,64'd16}, done pulse.
//  2. AAD 5B keep=16'h001F, data all 0xFF -> aad_data=128'h...00FF_FFFF_FFFF (upper 11 bytes 0).
//  3. cfg_aad_en=0, pld 40B (FFFF,FFFF,00FF) -> 3 pld beats, len_block={64'd40,64'd0}.
//  4. Hold aad_ready=0 5 cycles then 1 -> aad_data stable, single handshake; no 2nd beat before aad_done.
//  5. Non-last beat keep=16'h00FF -> err=1, no downstream valid, start clears err.
//  6. rst_n low during P_ACK -> all outputs 0 next edge; fresh start completes message normally.

Source files
------------

// File: rtl/poly1305_block_feeder.sv
// Producer for the Poly1305 AAD/payload/length block interface: captures one upstream beat at a
// time, zero-pads bytes beyond keep, counts bytes and emits the le64(aad)||le64(pld) length block.
module poly1305_block_feeder #(
    parameter int CNT_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_aad_en,
    input  logic             cfg_pld_en,
    input  logic             s_aad_valid,
    output logic             s_aad_ready,
    input  logic [127:0]     s_aad_data,
    input  logic [15:0]      s_aad_keep,
    input  logic             s_aad_last,
    input  logic             s_pld_valid,
    output logic             s_pld_ready,
    input  logic [127:0]     s_pld_data,
    input  logic [15:0]      s_pld_keep,
    input  logic             s_pld_last,
    output logic             aad_valid,
    output logic [127:0]     aad_data,
    output logic [15:0]      aad_keep,
    input  logic             aad_ready,
    output logic             pld_valid,
    output logic [127:0]     pld_data,
    output logic [15:0]      pld_keep,
    input  logic             pld_ready,
    output logic             len_valid,
    output logic [127:0]     len_block,
    input  logic             len_ready,
    input  logic             aad_done,
    input  logic             pld_done,
    input  logic             lens_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] aad_bytes,
    output logic [CNT_W-1:0] pld_bytes
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_A_RX  = 4'd1;
    localparam logic [3:0] S_A_TX  = 4'd2;
    localparam logic [3:0] S_A_ACK = 4'd3;
    localparam logic [3:0] S_P_RX  = 4'd4;
    localparam logic [3:0] S_P_TX  = 4'd5;
    localparam logic [3:0] S_P_ACK = 4'd6;
    localparam logic [3:0] S_L_TX  = 4'd7;
    localparam logic [3:0] S_L_ACK = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;
    localparam logic [3:0] S_ERR   = 4'd10;

    // A keep is a contiguous run of k low bytes (k>=1); partial runs only on the final beat.
    function automatic logic keep_legal(input logic [15:0] keep, input logic last);
        return (keep != 16'h0) && ((keep & (keep + 16'h1)) == 16'h0) &&
               (last || (keep == 16'hFFFF));
    endfunction

    function automatic logic [127:0] mask_bytes(input logic [127:0] data, input logic [15:0] keep);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            res[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    function automatic logic [4:0] popcnt(input logic [15:0] keep);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, keep[i]};
        end
        return n;
    endfunction

    logic [3:0]       state_q, state_d;
    logic [127:0]     data_q, data_d;
    logic [15:0]      keep_q, keep_d;
    logic             last_q, last_d;
    logic             pen_q, pen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] aad_cnt_q, aad_cnt_d;
    logic [CNT_W-1:0] pld_cnt_q, pld_cnt_d;
    logic [127:0]     len_q, len_d;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        pen_d     = pen_q;
        err_d     = err_q;
        aad_cnt_d = aad_cnt_q;
        pld_cnt_d = pld_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    aad_cnt_d = '0;
                    pld_cnt_d = '0;
                    err_d     = 1'b0;
                    pen_d     = cfg_pld_en;
                    state_d   = cfg_aad_en ? S_A_RX : (cfg_pld_en ? S_P_RX : S_L_TX);
                end
            end
            S_A_RX: begin
                if (s_aad_valid) begin
                    if (keep_legal(s_aad_keep, s_aad_last)) begin
                        data_d    = mask_bytes(s_aad_data, s_aad_keep);
                        keep_d    = s_aad_keep;
                        last_d    = s_aad_last;
                        aad_cnt_d = aad_cnt_q + CNT_W'(popcnt(s_aad_keep));
                        state_d   = S_A_TX;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_A_TX:  if (aad_ready) state_d = S_A_ACK;
            S_A_ACK: if (aad_done) state_d = last_q ? (pen_q ? S_P_RX : S_L_TX) : S_A_RX;
            S_P_RX: begin
                if (s_pld_valid) begin
                    if (keep_legal(s_pld_keep, s_pld_last)) begin
                        data_d    = mask_bytes(s_pld_data, s_pld_keep);
                        keep_d    = s_pld_keep;
                        last_d    = s_pld_last;
                        pld_cnt_d = pld_cnt_q + CNT_W'(popcnt(s_pld_keep));
                        state_d   = S_P_TX;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_P_TX:  if (pld_ready) state_d = S_P_ACK;
            S_P_ACK: if (pld_done) state_d = last_q ? S_L_TX : S_P_RX;
            S_L_TX:  if (len_ready) state_d = S_L_ACK;
            S_L_ACK: if (lens_done) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Length block snapshots the counters on the cycle the FSM enters L_TX.
    always_comb begin
        len_d = len_q;
        if ((state_d == S_L_TX) && (state_q != S_L_TX)) begin
            len_d = {64'(pld_cnt_d), 64'(aad_cnt_d)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            pen_q     <= 1'b0;
            err_q     <= 1'b0;
            aad_cnt_q <= '0;
            pld_cnt_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            pen_q     <= pen_d;
            err_q     <= err_d;
            aad_cnt_q <= aad_cnt_d;
            pld_cnt_q <= pld_cnt_d;
            len_q     <= len_d;
        end
    end

    assign s_aad_ready = (state_q == S_A_RX);
    assign s_pld_ready = (state_q == S_P_RX);
    assign aad_valid   = (state_q == S_A_TX);
    assign pld_valid   = (state_q == S_P_TX);
    assign len_valid   = (state_q == S_L_TX);
    assign aad_data    = data_q;
    assign aad_keep    = keep_q;
    assign pld_data    = data_q;
    assign pld_keep    = keep_q;
    assign len_block   = len_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign done        = (state_q == S_L_ACK) && lens_done;
    assign err         = err_q;
    assign aad_bytes   = aad_cnt_q;
    assign pld_bytes   = pld_cnt_q;

endmodule

// File: tb/tb_poly1305_block_feeder.sv
// Randomised bench for poly1305_block_feeder: message-level model (queues of beats, byte counts,
// current stream) compared against every DUT output once per cycle, plus literal pins.
module tb_poly1305_block_feeder;
    localparam int CNT_W = 36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start, cfg_aad_en, cfg_pld_en;
    logic s_aad_valid, s_aad_ready, s_aad_last;
    logic [127:0] s_aad_data;
    logic [15:0] s_aad_keep;
    logic s_pld_valid, s_pld_ready, s_pld_last;
    logic [127:0] s_pld_data;
    logic [15:0] s_pld_keep;
    logic aad_valid, aad_ready, pld_valid, pld_ready, len_valid, len_ready;
    logic [127:0] aad_data, pld_data, len_block;
    logic [15:0] aad_keep, pld_keep;
    logic aad_done, pld_done, lens_done, busy, done, err;
    logic [CNT_W-1:0] aad_bytes, pld_bytes;

    always #5 clk = ~clk;

    poly1305_block_feeder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_aad_en(cfg_aad_en), .cfg_pld_en(cfg_pld_en),
        .s_aad_valid(s_aad_valid), .s_aad_ready(s_aad_ready), .s_aad_data(s_aad_data),
        .s_aad_keep(s_aad_keep), .s_aad_last(s_aad_last),
        .s_pld_valid(s_pld_valid), .s_pld_ready(s_pld_ready), .s_pld_data(s_pld_data),
        .s_pld_keep(s_pld_keep), .s_pld_last(s_pld_last),
        .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
        .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
        .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
        .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
        .busy(busy), .done(done), .err(err), .aad_bytes(aad_bytes), .pld_bytes(pld_bytes)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t up_a[$], up_p[$], ex_a[$], ex_p[$];
    int errors = 0;
    int checks = 0;

    // message-level model: stream 1=AAD 2=payload 3=length 4=finished; pend = stream awaiting done
    bit m_active, m_err, m_pen, pend_last;
    int m_stage, pend, dly;
    logic [CNT_W-1:0] m_acnt, m_pcnt;
    logic [127:0] m_len;
    bit f_start, f_sa, f_sp, f_a, f_p, f_l, f_ad, f_pd, f_ld;
    bit start_req, cfg_a, cfg_p, rst_req, msg_end, hold_force;
    int hold_a, end_kind, a_hs, p_hs;
    logic [127:0] got_len, got_a0;
    logic [15:0] got_k0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_idle();
        start = 0; cfg_aad_en = 0; cfg_pld_en = 0;
        s_aad_valid = 0; s_aad_data = '0; s_aad_keep = '0; s_aad_last = 0;
        s_pld_valid = 0; s_pld_data = '0; s_pld_keep = '0; s_pld_last = 0;
        aad_ready = 0; pld_ready = 0; len_ready = 0;
        aad_done = 0; pld_done = 0; lens_done = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {s_aad_ready, s_pld_ready, aad_valid, pld_valid, len_valid, busy, done, err}, '0);
        chk({tag, "_aad_data"}, aad_data, '0);
        chk({tag, "_pld_data"}, pld_data, '0);
        chk({tag, "_keeps"}, {aad_keep, pld_keep}, '0);
        chk({tag, "_len"}, len_block, '0);
        chk({tag, "_counts"}, {aad_bytes, pld_bytes}, '0);
    endtask

    task automatic enter_stage(input int s);
        m_stage = s;
        if (s == 3) m_len = {64'(m_pcnt), 64'(m_acnt)};
    endtask

    task automatic absorb(input beat_t b, input int ch);
        int n;
        beat_t m;
        n = $countones(b.k);
        if (n > 0 && b.k == (16'hFFFF >> (16 - n)) && (b.l || n == 16)) begin
            m = b;
            for (int i = 0; i < 16; i++) if (!b.k[i]) m.d[8*i +: 8] = 8'h00;
            if (ch == 1) begin ex_a.push_back(m); m_acnt += CNT_W'(n); end
            else begin ex_p.push_back(m); m_pcnt += CNT_W'(n); end
        end else begin
            m_err = 1; m_active = 0; m_stage = 0;
            up_a.delete(); up_p.delete();
            msg_end = 1; end_kind = 2;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1;
        up_a.delete(); up_p.delete(); ex_a.delete(); ex_p.delete();
        m_active = 0; m_err = 0; m_stage = 0; pend = 0; m_acnt = '0; m_pcnt = '0;
        rst_req = 0; msg_end = 1; end_kind = 3;
    endtask

    task automatic step();
        beat_t t;
        bit exp_ra, exp_rp, exp_lv;
        @(negedge clk);
        // account for the clock edge that just passed
        if (f_start) begin
            m_active = 1; m_err = 0; m_acnt = '0; m_pcnt = '0; m_pen = cfg_p; start_req = 0;
            enter_stage(cfg_a ? 1 : (cfg_p ? 2 : 3));
        end
        if (f_sa) absorb(up_a.pop_front(), 1);
        if (f_sp) absorb(up_p.pop_front(), 2);
        if (f_a) begin t = ex_a.pop_front(); pend_last = t.l; pend = 1; dly = $urandom_range(0, 3); end
        if (f_p) begin t = ex_p.pop_front(); pend_last = t.l; pend = 2; dly = $urandom_range(0, 3); end
        if (f_l) begin pend = 3; dly = $urandom_range(0, 3); end
        if (f_ad) begin pend = 0; if (pend_last) enter_stage(m_pen ? 2 : 3); end
        if (f_pd) begin pend = 0; if (pend_last) enter_stage(3); end
        if (f_ld) begin pend = 0; m_stage = 4; m_active = 0; msg_end = 1; end_kind = 1; end
        {f_start, f_sa, f_sp, f_a, f_p, f_l, f_ad, f_pd, f_ld} = '0;

        exp_ra = m_active && m_stage == 1 && ex_a.size() == 0 && pend == 0;
        exp_rp = m_active && m_stage == 2 && ex_p.size() == 0 && pend == 0;
        exp_lv = m_active && m_stage == 3 && pend == 0;
        chk("busy", busy, m_active);
        chk("err", err, m_err);
        chk("aad_bytes", aad_bytes, m_acnt);
        chk("pld_bytes", pld_bytes, m_pcnt);
        chk("s_aad_ready", s_aad_ready, exp_ra);
        chk("s_pld_ready", s_pld_ready, exp_rp);
        chk("aad_valid", aad_valid, ex_a.size() > 0);
        chk("pld_valid", pld_valid, ex_p.size() > 0);
        chk("len_valid", len_valid, exp_lv);
        if (ex_a.size() > 0) begin chk("aad_data", aad_data, ex_a[0].d); chk("aad_keep", aad_keep, ex_a[0].k); end
        if (ex_p.size() > 0) begin chk("pld_data", pld_data, ex_p[0].d); chk("pld_keep", pld_keep, ex_p[0].k); end
        if (exp_lv) chk("len_block", len_block, m_len);

        if (rst_req && pend == 2) begin
            do_reset();
            return;
        end
        // drive inputs for the next edge
        start = 0;
        if (start_req && !m_active) begin
            start = 1; cfg_aad_en = cfg_a; cfg_pld_en = cfg_p;
        end else if (m_active && $urandom_range(0, 15) == 0) begin
            start = 1; cfg_aad_en = 1'($urandom); cfg_pld_en = 1'($urandom);
        end
        if (up_a.size() > 0 && $urandom_range(0, 3) != 0) begin
            s_aad_valid = 1; s_aad_data = up_a[0].d; s_aad_keep = up_a[0].k; s_aad_last = up_a[0].l;
        end else begin
            s_aad_valid = 0; s_aad_data = {$urandom, $urandom, $urandom, $urandom};
            s_aad_keep = 16'($urandom); s_aad_last = 1'($urandom);
        end
        if (up_p.size() > 0 && $urandom_range(0, 3) != 0) begin
            s_pld_valid = 1; s_pld_data = up_p[0].d; s_pld_keep = up_p[0].k; s_pld_last = up_p[0].l;
        end else begin
            s_pld_valid = 0; s_pld_data = {$urandom, $urandom, $urandom, $urandom};
            s_pld_keep = 16'($urandom); s_pld_last = 1'($urandom);
        end
        if (hold_a > 0) begin
            aad_ready = 0;
            if (ex_a.size() > 0) hold_a--;
        end else begin
            aad_ready = hold_force ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        pld_ready = $urandom_range(0, 3) != 0;
        len_ready = $urandom_range(0, 3) != 0;
        aad_done = 0; pld_done = 0; lens_done = 0;
        if (pend != 0) begin
            if (dly == 0) begin
                if (pend == 1) aad_done = 1;
                else if (pend == 2) pld_done = 1;
                else lens_done = 1;
            end else dly--;
        end
        if (pend != 1 && $urandom_range(0, 7) == 0) aad_done = 1;
        if (pend != 2 && $urandom_range(0, 7) == 0) pld_done = 1;
        if (pend != 3 && $urandom_range(0, 7) == 0) lens_done = 1;
        #1;
        f_start = start && !m_active;
        f_sa = s_aad_valid && exp_ra;
        f_sp = s_pld_valid && exp_rp;
        f_a = aad_ready && ex_a.size() > 0;
        f_p = pld_ready && ex_p.size() > 0;
        f_l = len_ready && exp_lv;
        f_ad = aad_done && pend == 1;
        f_pd = pld_done && pend == 2;
        f_ld = lens_done && pend == 3;
        if (f_a) begin
            if (a_hs == 0) begin got_a0 = aad_data; got_k0 = aad_keep; end
            a_hs++;
        end
        if (f_p) p_hs++;
        if (f_l) got_len = len_block;
        chk("done", done, f_ld);
    endtask

    task automatic add_beats(input int ch, input int n, input int mode);
        beat_t b;
        int rem, k;
        rem = n;
        while (rem > 0) begin
            k = (rem > 16) ? 16 : rem;
            b.d = (mode == 1) ? {128{1'b1}} : {$urandom, $urandom, $urandom, $urandom};
            b.k = 16'hFFFF >> (16 - k);
            b.l = (rem == k);
            if (ch == 1) up_a.push_back(b); else up_p.push_back(b);
            rem -= k;
        end
    endtask

    // mode: 0 random data, 1 all-0xFF data, 2 first AAD beat non-last with partial keep
    task automatic run_msg(input bit aen, input bit pen, input int an, input int pn, input int mode);
        beat_t b;
        if (mode == 2) begin
            b.d = {$urandom, $urandom, $urandom, $urandom}; b.k = 16'h00FF; b.l = 1'b0;
            up_a.push_back(b);
        end else if (aen) add_beats(1, an, mode);
        if (pen) add_beats(2, pn, mode);
        cfg_a = aen; cfg_p = pen; start_req = 1; msg_end = 0; end_kind = 0;
        a_hs = 0; p_hs = 0; got_len = '0;
        for (int c = 0; c < 4000 && !msg_end; c++) step();
        if (!msg_end) begin
            checks++; errors++;
            $display("FAIL msg_timeout: got no completion expected done/err within 4000 cycles");
        end
        if (end_kind == 1) chk("len_total", got_len, {64'(pn), 64'(an)});
    endtask

    initial begin
        drive_idle();
        {f_start, f_sa, f_sp, f_a, f_p, f_l, f_ad, f_pd, f_ld} = '0;
        m_active = 0; m_err = 0; m_pen = 0; pend_last = 0; m_stage = 0; pend = 0; dly = 0;
        m_acnt = '0; m_pcnt = '0; m_len = '0;
        start_req = 0; rst_req = 0; hold_force = 0; hold_a = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        run_msg(1, 1, 16, 16, 0);
        chk("t1_len", got_len, {64'd16, 64'd16});
        chk("t1_beats", {a_hs, p_hs}, {32'd1, 32'd1});

        run_msg(1, 0, 5, 0, 1);
        chk("t2_data", got_a0, 128'h0000_0000_0000_0000_0000_00FF_FFFF_FFFF);
        chk("t2_keep", got_k0, 16'h001F);

        run_msg(0, 1, 0, 40, 0);
        chk("t3_len", got_len, {64'd40, 64'd0});
        chk("t3_beats", p_hs, 3);

        hold_a = 5; hold_force = 1;
        run_msg(1, 1, 16, 3, 0);
        hold_force = 0;
        chk("t4_hold_done", hold_a, 0);
        chk("t4_beats", a_hs, 1);

        run_msg(1, 1, 32, 16, 2);
        chk("t5_err", err, 1);
        chk("t5_no_fwd", a_hs, 0);
        run_msg(1, 1, 3, 3, 0);
        chk("t5_err_cleared", err, 0);

        rst_req = 1;
        run_msg(1, 1, 20, 50, 0);
        chk("t6_reset_hit", end_kind, 3);
        run_msg(1, 1, 7, 9, 0);
        chk("t6_recovered", end_kind, 1);

        for (int i = 0; i < 25; i++) begin
            bit ae, pe;
            ae = 1'($urandom); pe = 1'($urandom);
            run_msg(ae, pe, ae ? $urandom_range(1, 80) : 0, pe ? $urandom_range(1, 80) : 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
